fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15: wait-cycle limit before mem_timeout asserts.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  in  1 each  control-unit strobes.
REQ-006 PCSource  in  2  next-PC select: 0 ALUResult, 1 ALUOut, 2 jump target, 3 hold.
REQ-007 Zero  in  1  ALU zero flag.
REQ-008 ALUResult, ALUOut  in  32  ALU combinational result and registered result.
REQ-009 mem_rdata  in  32  memory read data, valid when mem_ready=1.
REQ-010 mem_ready  in  1  memory completes the current request this cycle.
REQ-011 mem_req, mem_we  out  1  memory request and write enable.
REQ-012 mem_addr  out  32  memory address.
REQ-013 PC, IR, MDR  out  32  program counter, instruction register, memory data register.
REQ-014 opcode  out  6  IR[31:26], fed to the control unit.
REQ-015 stall  out  1  memory transaction pending; control unit holds its state.
REQ-016 mem_timeout  out  1  sticky wait-limit error.
REQ-017 misalign  out  1  sticky misaligned-PC-target flag (only when the configuration macro is defined).

Function
REQ-018 Memory FSM states: IDLE, WAIT.
REQ-019 IDLE, MemRead or MemWrite=1: mem_req=1 combinationally; mem_addr = IorD ? ALUOut : PC; mem_we=MemWrite.
REQ-020 MemRead and MemWrite both 1: the write wins and the read is ignored (no IR/MDR load).
REQ-021 IDLE with mem_ready=1 in the request cycle completes with zero wait: stall=0, stay in IDLE.
REQ-022 IDLE with mem_ready=0: latch address, we and IRWrite; next state WAIT.
REQ-023 WAIT: mem_req=1 with latched address/we; stall=1 until the cycle mem_ready=1, then return to IDLE.
REQ-024 Read completion: MDR<=mem_rdata; IR<=mem_rdata only if IRWrite (live in IDLE, latched in WAIT).
REQ-025 Wait counter (4 bits) counts WAIT cycles; reaching MAX_WAIT sets mem_timeout, FSM returns to IDLE, no load.
REQ-026 pc_en = (PCWrite | (PCWriteCond & Zero)) & ~stall; PC loads the PCSource selection at posedge when pc_en=1.
REQ-027 Jump target = {PC[31:28], IR[25:0], 2'b00}.
REQ-028 PCSource=3 with pc_en=1 leaves PC unchanged.
REQ-029 PC wraps modulo 2^32; no overflow flag.
REQ-030 opcode is always IR[31:26]; IR changes only on a qualifying read completion.

Reset
REQ-031 Reset=1 at posedge: PC=RESET_PC, IR=0, MDR=0, FSM=IDLE, wait counter=0, mem_timeout=0, misalign=0.
REQ-032 During reset: mem_req=0, mem_we=0, stall=0; a transaction in WAIT is aborted with no loads.
REQ-033 Reset takes priority over every other input in the same cycle.

Configuration
REQ-034 Macro FETCH_MISALIGN_TRAP_EN defined: a PC load whose target[1:0]!=0 is suppressed and sets sticky misalign.
REQ-035 Macro FETCH_MISALIGN_TRAP_EN undefined: target[1:0] are forced to 0 on PC load; misalign is tied 0.

Verification
REQ-036 Reset, then MemRead=1, IRWrite=1, PCWrite=1, PCSource=0, ALUResult=4, mem_ready=1, mem_rdata=32'h1000_0003 -> IR=32'h1000_0003, opcode=6'd4, PC=4, stall=0.
REQ-037 MemRead=1, IRWrite=1, mem_ready low 3 cycles -> stall=1 for 3 cycles, PC unchanged; IR loads when mem_ready rises; FSM returns to IDLE.
REQ-038 PCWriteCond=1, PCSource=1, ALUOut=32'h40: Zero=0 -> PC unchanged; Zero=1 -> PC=32'h40.
REQ-039 IR=32'h0800_0010, PC=32'hA000_0000, PCWrite=1, PCSource=2 -> PC=32'hA000_0040.
REQ-040 Reset asserted during WAIT -> next cycle mem_req=0, PC=RESET_PC, IR=0.
REQ-041 ALUResult=32'h6 with PCWrite=1: macro defined -> PC unchanged, misalign=1; macro undefined -> PC=4.

Source files
------------

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Memory bus between the fetch/memory stage of the multicycle CPU and the
// instruction/data memory.
//
//   mem_req   : fetch -> mem  request strobe (held until mem_ready)
//   mem_we    : fetch -> mem  1 = write, 0 = read
//   mem_addr  : fetch -> mem  byte address
//   mem_rdata : mem -> fetch  read data, valid when mem_ready=1
//   mem_ready : mem -> fetch  current request completes this cycle
//
// Modports: master (fetch stage side), slave (memory side).
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// PC / IR / MDR datapath of a multicycle MIPS-style CPU together with a small
// memory handshake FSM (IDLE/WAIT) that stretches memory accesses and raises
// stall so the control unit holds its state while a transaction is pending.
//
// Parameters
//   RESET_PC : PC value loaded on reset
//   MAX_WAIT : number of WAIT cycles (1..15) before the access is abandoned
//              and the sticky mem_timeout flag is set
//
// Ports
//   clk, Reset        : clock, synchronous active-high reset
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite : control strobes
//   PCSource[1:0]     : next PC select (0 ALUResult, 1 ALUOut, 2 jump, 3 hold)
//   Zero              : ALU zero flag (for conditional PC write)
//   ALUResult, ALUOut : ALU combinational / registered result
//   mem               : memory bus (fetch_stage_if.master)
//   PC, IR, MDR       : architectural registers
//   opcode            : IR[31:26]
//   stall             : memory transaction pending this cycle
//   mem_timeout       : sticky wait-limit error
//   misalign          : sticky misaligned PC target flag
//
// Configuration macro
//   FETCH_MISALIGN_TRAP_EN : when defined, a PC load with target[1:0]!=0 is
//   suppressed and sets misalign. When undefined, the low two target bits are
//   cleared on load and misalign is tied low.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 PCWrite,
    input  logic                 PCWriteCond,
    input  logic                 IorD,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 IRWrite,
    input  logic [1:0]           PCSource,
    input  logic                 Zero,
    input  logic [31:0]          ALUResult,
    input  logic [31:0]          ALUOut,
    fetch_stage_if.master        mem,
    output logic [31:0]          PC,
    output logic [31:0]          IR,
    output logic [31:0]          MDR,
    output logic [5:0]           opcode,
    output logic                 stall,
    output logic                 mem_timeout,
    output logic                 misalign
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic        we_q;
    logic        irw_q;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_inc;

    // Combinational FSM decodes
    logic        req_new;
    logic [31:0] addr_new;
    logic        ld_mdr;
    logic        ld_ir;
    logic        latch_req;
    logic        timeout_evt;
    logic        cnt_step;

    // PC path
    logic        pc_en;
    logic [31:0] pc_sel;
    logic [31:0] pc_tgt;
    logic        pc_ld;

    assign req_new      = MemRead | MemWrite;
    assign addr_new     = IorD ? ALUOut : PC;
    assign wait_cnt_inc = wait_cnt + 4'd1;
    assign opcode       = IR[31:26];

    // -------------------------------------------------------------------------
    // Memory FSM: next state and bus outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_addr = addr_new;
        stall        = 1'b0;
        ld_mdr       = 1'b0;
        ld_ir        = 1'b0;
        latch_req    = 1'b0;
        timeout_evt  = 1'b0;
        cnt_step     = 1'b0;

        // Reset silences the bus and aborts any pending access.
        if (!Reset) begin
            case (state)
                IDLE: begin
                    if (req_new) begin
                        mem.mem_req = 1'b1;
                        mem.mem_we  = MemWrite;
                        if (mem.mem_ready) begin
                            // Zero-wait completion; a write overrides a read.
                            ld_mdr = ~MemWrite;
                            ld_ir  = ~MemWrite & IRWrite;
                        end else begin
                            // Stall already in the request cycle so the control
                            // unit cannot advance PC past the pending fetch.
                            stall     = 1'b1;
                            latch_req = 1'b1;
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    mem.mem_req  = 1'b1;
                    mem.mem_we   = we_q;
                    mem.mem_addr = addr_q;
                    if (mem.mem_ready) begin
                        ld_mdr    = ~we_q;
                        ld_ir     = irw_q;
                        state_nxt = IDLE;
                    end else begin
                        stall = 1'b1;
                        if (wait_cnt_inc == WAIT_LIMIT) begin
                            // Give up: flag the error, drop the access, no loads.
                            timeout_evt = 1'b1;
                            state_nxt   = IDLE;
                        end else begin
                            cnt_step = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next-PC selection
    // -------------------------------------------------------------------------
    always_comb begin
        case (PCSource)
            2'd0:    pc_sel = ALUResult;
            2'd1:    pc_sel = ALUOut;
            2'd2:    pc_sel = {PC[31:28], IR[25:0], 2'b00};
            default: pc_sel = PC;
        endcase
    end

    assign pc_en = (PCWrite | (PCWriteCond & Zero)) & ~stall;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_set;
    logic misalign_q;

    assign pc_tgt   = pc_sel;
    assign pc_ld    = pc_en & (pc_sel[1:0] == 2'b00);
    assign mis_set  = pc_en & (pc_sel[1:0] != 2'b00);
    assign misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            misalign_q <= 1'b0;
        end else if (mis_set) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign pc_tgt   = {pc_sel[31:2], 2'b00};
    assign pc_ld    = pc_en;
    assign misalign = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State and architectural registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            mem_timeout <= 1'b0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            irw_q       <= 1'b0;
            PC          <= RESET_PC;
            IR          <= 32'd0;
            MDR         <= 32'd0;
        end else begin
            state <= state_nxt;

            if (latch_req) begin
                addr_q   <= addr_new;
                we_q     <= MemWrite;
                irw_q    <= IRWrite & ~MemWrite;
                wait_cnt <= 4'd0;
            end else if (cnt_step) begin
                wait_cnt <= wait_cnt_inc;
            end else begin
                wait_cnt <= 4'd0;
            end

            if (timeout_evt) begin
                mem_timeout <= 1'b1;
            end

            if (ld_mdr) begin
                MDR <= mem.mem_rdata;
            end
            if (ld_ir) begin
                IR <= mem.mem_rdata;
            end

            if (pc_ld) begin
                PC <= pc_tgt;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage: reset, zero-wait and stretched fetches,
// write-over-read priority, conditional PC write, jump target, hold, misalign
// handling, wait-limit timeout and reset abort of a pending access.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        Reset;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0]  PCSource;
    logic        Zero;
    logic [31:0] ALUResult, ALUOut;
    logic [31:0] PC, IR, MDR;
    logic [5:0]  opcode;
    logic        stall, mem_timeout, misalign;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .PCSource    (PCSource),
        .Zero        (Zero),
        .ALUResult   (ALUResult),
        .ALUOut      (ALUOut),
        .mem         (bus),
        .PC          (PC),
        .IR          (IR),
        .MDR         (MDR),
        .opcode      (opcode),
        .stall       (stall),
        .mem_timeout (mem_timeout),
        .misalign    (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with a read request present: bus must stay quiet
        Reset = 1'b1;
        PCWrite = 0; PCWriteCond = 0; IorD = 0; MemRead = 1; MemWrite = 0; IRWrite = 0;
        PCSource = 2'd0; Zero = 0; ALUResult = 32'd0; ALUOut = 32'd0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
        #1;
        chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rst_we",    {31'd0, bus.mem_we},  32'd0);
        chk("rst_stall", {31'd0, stall},       32'd0);
        tick();
        chk("rst_pc",   PC,  32'd0);
        chk("rst_ir",   IR,  32'd0);
        chk("rst_mdr",  MDR, 32'd0);
        chk("rst_tmo",  {31'd0, mem_timeout}, 32'd0);
        chk("rst_mis",  {31'd0, misalign},    32'd0);

        // Zero-wait instruction fetch with PC+4
        Reset = 1'b0;
        MemRead = 1; IRWrite = 1; PCWrite = 1; PCSource = 2'd0; ALUResult = 32'd4;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1000_0003;
        #1;
        chk("zw_req",   {31'd0, bus.mem_req}, 32'd1);
        chk("zw_addr",  bus.mem_addr,          32'd0);
        chk("zw_stall", {31'd0, stall},        32'd0);
        tick();
        chk("zw_ir",     IR,             32'h1000_0003);
        chk("zw_opcode", {26'd0, opcode}, 32'd4);
        chk("zw_pc",     PC,             32'd4);
        chk("zw_mdr",    MDR,            32'h1000_0003);

        // Fetch stretched by three not-ready cycles
        ALUResult = 32'd8; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h2000_0005;
        #1;
        chk("ws1_stall", {31'd0, stall}, 32'd1);
        chk("ws1_addr",  bus.mem_addr,    32'd4);
        tick();
        chk("ws1_pc", PC, 32'd4);
        IorD = 1; ALUOut = 32'h100;   // must not disturb the latched address
        #1;
        chk("ws2_stall", {31'd0, stall},       32'd1);
        chk("ws2_addr",  bus.mem_addr,          32'd4);
        chk("ws2_req",   {31'd0, bus.mem_req}, 32'd1);
        tick();
        chk("ws2_pc", PC, 32'd4);
        chk("ws3_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("ws3_pc", PC, 32'd4);
        chk("ws3_ir", IR, 32'h1000_0003);
        bus.mem_ready = 1'b1;
        #1;
        chk("wsd_stall", {31'd0, stall}, 32'd0);
        chk("wsd_addr",  bus.mem_addr,    32'd4);
        tick();
        chk("wsd_ir", IR, 32'h2000_0005);
        chk("wsd_pc", PC, 32'd8);
        MemRead = 0; IRWrite = 0; PCWrite = 0; IorD = 0; bus.mem_ready = 1'b0;
        #1;
        chk("idle_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("idle_stall", {31'd0, stall},       32'd0);

        // Read and write together: write wins, no loads
        MemRead = 1; MemWrite = 1; IRWrite = 1; IorD = 1; ALUOut = 32'h100;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_we",   {31'd0, bus.mem_we}, 32'd1);
        chk("wr_addr", bus.mem_addr,         32'h100);
        tick();
        chk("wr_ir",  IR,  32'h2000_0005);
        chk("wr_mdr", MDR, 32'h2000_0005);

        // Data read: MDR loads, IR untouched
        MemWrite = 0; IRWrite = 0; bus.mem_rdata = 32'h1234_5678;
        tick();
        chk("rd_mdr", MDR, 32'h1234_5678);
        chk("rd_ir",  IR,  32'h2000_0005);
        MemRead = 0; IorD = 0; bus.mem_ready = 1'b0;

        // Conditional PC write from ALUOut
        PCWriteCond = 1; PCSource = 2'd1; ALUOut = 32'h40; Zero = 0;
        tick();
        chk("bc_nz_pc", PC, 32'd8);
        Zero = 1;
        tick();
        chk("bc_z_pc", PC, 32'h40);
        PCWriteCond = 0; Zero = 0;

        // Jump target from IR and PC upper nibble
        MemRead = 1; IRWrite = 1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0800_0010;
        tick();
        chk("j_ir",     IR,              32'h0800_0010);
        chk("j_opcode", {26'd0, opcode}, 32'd2);
        MemRead = 0; IRWrite = 0; bus.mem_ready = 1'b0;
        PCWrite = 1; PCSource = 2'd0; ALUResult = 32'hA000_0000;
        tick();
        chk("j_pcset", PC, 32'hA000_0000);
        PCSource = 2'd2;
        tick();
        chk("j_pc", PC, 32'hA000_0040);
        PCSource = 2'd3;
        tick();
        chk("hold_pc", PC, 32'hA000_0040);

        // Misaligned target
        PCSource = 2'd0; ALUResult = 32'h6;
        tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_pc",  PC,                 32'hA000_0040);
        chk("mis_flg", {31'd0, misalign},  32'd1);
`else
        chk("mis_pc",  PC,                 32'd4);
        chk("mis_flg", {31'd0, misalign},  32'd0);
`endif
        PCWrite = 0;

        // Wait-limit timeout: 1 request cycle + 15 WAIT cycles
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("tmo_mis_clr", {31'd0, misalign}, 32'd0);
        MemRead = 1; IRWrite = 1; bus.mem_ready = 1'b0; bus.mem_rdata = 32'hCAFE_F00D;
        repeat (15) tick();
        chk("tmo_pre",       {31'd0, mem_timeout}, 32'd0);
        chk("tmo_pre_stall", {31'd0, stall},       32'd1);
        tick();
        chk("tmo_set", {31'd0, mem_timeout}, 32'd1);
        chk("tmo_ir",  IR,                    32'd0);
        MemRead = 0; IRWrite = 0;
        #1;
        chk("tmo_idle_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("tmo_idle_stall", {31'd0, stall},       32'd0);
        tick();
        chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);

        // Reset aborts a pending access
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("ra_tmo_clr", {31'd0, mem_timeout}, 32'd0);
        PCWrite = 1; ALUResult = 32'h20;
        tick();
        chk("ra_pcset", PC, 32'h20);
        PCWrite = 0;
        MemRead = 1; IRWrite = 1; bus.mem_ready = 1'b0;
        tick();
        chk("ra_wait_stall", {31'd0, stall}, 32'd1);
        Reset = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("ra_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("ra_stall", {31'd0, stall},       32'd0);
        tick();
        Reset = 1'b0; MemRead = 0; IRWrite = 0; bus.mem_ready = 1'b0;
        #1;
        chk("ra_post_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("ra_post_stall", {31'd0, stall},       32'd0);
        chk("ra_pc",  PC,  32'd0);
        chk("ra_ir",  IR,  32'd0);
        chk("ra_mdr", MDR, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
